aes_round_ctrl: RTL and testbench

Round sequencer for the AES-128 encryption datapath. Walks one 128-bit block through the initial key addition, nine full rounds and the final round. It does this by handshaking with the key-expansion unit and the four round-transform wrappers: sub-bytes, shift-rows, mix-columns and add-round-key (`around_enable`/`around_finished`). It also drives the select and write-enable of the shared state register. It holds no data itself.

---
 rtl/aes_round_ctrl.sv | 141 ++++++++++++++
 tb/tb_aes_round_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: steps one block through key addition, full rounds and the
// final round by handshaking with key expansion and the four round-transform wrappers.
module aes_round_ctrl #(
    parameter int NUM_ROUNDS = 10,
    parameter int TIMEOUT    = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [3:0] round,
    output logic       key_req,
    output logic [3:0] key_round,
    input  logic       key_ready,
    output logic       sub_enable,
    input  logic       sub_finished,
    output logic       shift_enable,
    input  logic       shift_finished,
    output logic       mix_enable,
    input  logic       mix_finished,
    output logic       around_enable,
    input  logic       around_finished,
    output logic [2:0] data_sel,
    output logic       state_we
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_KEYREQ, S_SUB, S_SHIFT, S_MIX, S_ARK, S_DONE
    } state_t;

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);
    localparam logic [7:0] WDOG_LAST  = 8'(TIMEOUT - 1);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_round;
    logic [7:0] r_wdog;
    logic       r_error;
    logic       w_wait;
    logic       w_hs;
    logic       w_tmo;
    logic       w_accept;

    // Only the active state's responder counts; finished strobes from idle blocks are ignored.
    always_comb begin
        w_hs   = 1'b0;
        w_wait = 1'b1;
        case (r_state)
            S_KEYREQ: w_hs = key_ready;
            S_SUB:    w_hs = sub_finished;
            S_SHIFT:  w_hs = shift_finished;
            S_MIX:    w_hs = mix_finished;
            S_ARK:    w_hs = around_finished;
            default:  w_wait = 1'b0;
        endcase
    end

    // A handshake arriving in the last allowed wait cycle beats the timeout.
    assign w_tmo    = w_wait && !w_hs && (r_wdog == WDOG_LAST);
    assign w_accept = (r_state == S_IDLE) && start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_LOAD;
            S_LOAD:   w_next = S_KEYREQ;
            S_KEYREQ: if (w_hs) w_next = (r_round == 4'd0) ? S_ARK : S_SUB;
            S_SUB:    if (w_hs) w_next = S_SHIFT;
            S_SHIFT:  if (w_hs) w_next = (r_round == LAST_ROUND) ? S_ARK : S_MIX;
            S_MIX:    if (w_hs) w_next = S_ARK;
            S_ARK:    if (w_hs) w_next = (r_round == LAST_ROUND) ? S_DONE : S_KEYREQ;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        if (w_tmo) begin
            w_next = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_round <= 4'd0;
            r_error <= 1'b0;
            r_wdog  <= 8'd0;
        end else begin
            if (w_accept) begin
                r_round <= 4'd0;
            end else if (r_state == S_ARK && w_hs && r_round != LAST_ROUND) begin
                r_round <= r_round + 4'd1;
            end

            if (w_accept) begin
                r_error <= 1'b0;
            end else if (w_tmo) begin
                r_error <= 1'b1;
            end

            // Restart the wait count on every state change, so each handshake state starts at zero.
            if (w_next != r_state) begin
                r_wdog <= 8'd0;
            end else if (w_wait) begin
                r_wdog <= r_wdog + 8'd1;
            end
        end
    end

    always_comb begin
        busy          = (r_state != S_IDLE);
        done          = (r_state == S_DONE);
        key_req       = (r_state == S_KEYREQ);
        sub_enable    = (r_state == S_SUB);
        shift_enable  = (r_state == S_SHIFT);
        mix_enable    = (r_state == S_MIX);
        around_enable = (r_state == S_ARK);
        state_we      = 1'b0;
        data_sel      = 3'd0;
        case (r_state)
            S_LOAD:  state_we = 1'b1;
            S_SUB:   if (w_hs) begin state_we = 1'b1; data_sel = 3'd1; end
            S_SHIFT: if (w_hs) begin state_we = 1'b1; data_sel = 3'd2; end
            S_MIX:   if (w_hs) begin state_we = 1'b1; data_sel = 3'd3; end
            S_ARK:   if (w_hs) begin state_we = 1'b1; data_sel = 3'd4; end
            default: ;
        endcase
    end

    assign round     = r_round;
    assign key_round = r_round;
    assign error     = r_error;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Scoreboard bench for aes_round_ctrl: stub responders, expected event queue, and a
// negedge monitor that pops one entry per key request, state write, done or error rise.
module tb_aes_round_ctrl;

    localparam int K_WE   = 0;
    localparam int K_DONE = 1;
    localparam int K_ERR  = 2;
    localparam int K_KEY  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start;
    logic       busy, done, error;
    logic [3:0] round, key_round;
    logic       key_req, key_ready;
    logic       sub_enable, sub_finished, shift_enable, shift_finished;
    logic       mix_enable, mix_finished, around_enable, around_finished;
    logic [2:0] data_sel;
    logic       state_we;

    logic start_drv = 1'b0;
    logic noise_on  = 1'b0;
    int   mix_hang_round = -1;
    int   sub_slow_round = -1;

    int key_cnt = 0, sub_cnt = 0, shift_cnt = 0, mix_cnt = 0, ark_cnt = 0;
    int cyc = 0;
    int start_cyc = 0;
    int errors = 0, checks = 0;

    typedef struct {
        int kind;
        int sel;
        int rnd;
        int lat;
    } exp_t;
    exp_t sbq[$];

    always #5 clk = ~clk;

    aes_round_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
        .round(round), .key_req(key_req), .key_round(key_round), .key_ready(key_ready),
        .sub_enable(sub_enable), .sub_finished(sub_finished),
        .shift_enable(shift_enable), .shift_finished(shift_finished),
        .mix_enable(mix_enable), .mix_finished(mix_finished),
        .around_enable(around_enable), .around_finished(around_finished),
        .data_sel(data_sel), .state_we(state_we)
    );

    // Stub responders: key answers 1 cycle after request, transforms 2 cycles after enable.
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        key_cnt   <= key_req ? key_cnt + 1 : 0;
        sub_cnt   <= sub_enable ? sub_cnt + 1 : 0;
        shift_cnt <= shift_enable ? shift_cnt + 1 : 0;
        mix_cnt   <= mix_enable ? mix_cnt + 1 : 0;
        ark_cnt   <= around_enable ? ark_cnt + 1 : 0;
    end

    assign key_ready       = key_req && key_cnt == 1;
    assign sub_finished    = sub_enable && sub_cnt == ((int'(round) == sub_slow_round) ? 254 : 2);
    assign shift_finished  = shift_enable && shift_cnt == 2;
    assign mix_finished    = mix_enable && mix_cnt == 2 && int'(round) != mix_hang_round;
    assign around_finished = (around_enable && ark_cnt == 2) || (noise_on && sub_enable);
    assign start           = start_drv || (noise_on && mix_enable);

    task automatic check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void push(int k, int s, int r, int l);
        exp_t e;
        e.kind = k; e.sel = s; e.rnd = r; e.lat = l;
        sbq.push_back(e);
    endfunction

    // Expected event stream for one block; hang > 0 stops with a timeout in that round's MIX.
    function automatic void push_run(int hang, int lat_done, int lat_err);
        push(K_WE, 0, 0, 0);
        push(K_KEY, 0, 0, 0);
        push(K_WE, 4, 0, 0);
        for (int r = 1; r <= 10; r++) begin
            push(K_KEY, 0, r, 0);
            push(K_WE, 1, r, 0);
            push(K_WE, 2, r, 0);
            if (r == hang) begin
                push(K_ERR, 0, r, lat_err);
                return;
            end
            if (r < 10) push(K_WE, 3, r, 0);
            push(K_WE, 4, r, 0);
        end
        push(K_DONE, 0, 10, lat_done);
    endfunction

    task automatic pop_cmp(int kind);
        exp_t e;
        if (sbq.size() == 0) begin
            check("unexpected_event_kind", kind, -1);
            return;
        end
        e = sbq.pop_front();
        check("event_kind", kind, e.kind);
        case (kind)
            K_KEY: check("key_round", int'(key_round), e.rnd);
            K_WE: begin
                check("data_sel", int'(data_sel), e.sel);
                check("write_round", int'(round), e.rnd);
            end
            K_DONE: begin
                check("done_latency", cyc - start_cyc + 1, e.lat);
                check("error_at_done", int'(error), 0);
            end
            default: begin
                check("error_latency", cyc - start_cyc + 1, e.lat);
                check("busy_after_timeout", int'(busy), 0);
                check("done_after_timeout", int'(done), 0);
            end
        endcase
    endtask

    logic pk = 1'b0, perr = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            pk   <= 1'b0;
            perr <= 1'b0;
        end else begin
            if (key_req && !pk) pop_cmp(K_KEY);
            if (state_we) pop_cmp(K_WE);
            if (done) pop_cmp(K_DONE);
            if (error && !perr) pop_cmp(K_ERR);
            pk   <= key_req;
            perr <= error;
        end
    end

    int n_key = 0, n_sub = 0, n_shift = 0, n_mix = 0, n_ark = 0, n_we = 0;
    logic p_key = 0, p_sub = 0, p_shift = 0, p_mix = 0, p_ark = 0;
    always @(negedge clk) begin
        if (key_req && !p_key) n_key <= n_key + 1;
        if (sub_enable && !p_sub) n_sub <= n_sub + 1;
        if (shift_enable && !p_shift) n_shift <= n_shift + 1;
        if (mix_enable && !p_mix) n_mix <= n_mix + 1;
        if (around_enable && !p_ark) n_ark <= n_ark + 1;
        if (state_we && !rst) n_we <= n_we + 1;
        p_key <= key_req; p_sub <= sub_enable; p_shift <= shift_enable;
        p_mix <= mix_enable; p_ark <= around_enable;
    end

    function automatic int outs();
        return int'({busy, done, error, key_req, key_round, sub_enable, shift_enable,
                     mix_enable, around_enable, data_sel, state_we});
    endfunction

    task automatic kick();
        @(negedge clk);
        start_drv = 1'b1;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        start_drv = 1'b0;
    endtask

    task automatic run_block(int budget);
        int waited;
        kick();
        waited = 0;
        while (busy && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        check("block_ends_within_budget", int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int s_key, s_sub, s_shift, s_mix, s_ark, s_we, waited;
        repeat (3) @(negedge clk);
        check("reset_outputs", outs(), 0);
        check("reset_round", int'(round), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Nominal block with enable counts.
        s_key = n_key; s_sub = n_sub; s_shift = n_shift; s_mix = n_mix; s_ark = n_ark; s_we = n_we;
        push_run(0, 144, 0);
        run_block(300);
        @(negedge clk);
        check("key_req_count", n_key - s_key, 11);
        check("sub_count", n_sub - s_sub, 10);
        check("shift_count", n_shift - s_shift, 10);
        check("mix_count", n_mix - s_mix, 9);
        check("ark_count", n_ark - s_ark, 11);
        check("state_we_count", n_we - s_we, 41);

        // MIX never answers in round 3: 42 cycles to reach MIX, 255 in MIX, error seen in cycle 298.
        mix_hang_round = 3;
        push_run(3, 0, 298);
        run_block(600);
        check("error_sticky", int'(error), 1);
        mix_hang_round = -1;
        push_run(0, 144, 0);
        run_block(300);
        check("error_cleared", int'(error), 0);

        // Round 2 SUB answers on its 255th wait cycle: 252 extra cycles, no error.
        sub_slow_round = 2;
        push_run(0, 396, 0);
        run_block(800);
        sub_slow_round = -1;

        // Asynchronous reset in round 5 ARK.
        push_run(0, 144, 0);
        kick();
        waited = 0;
        while (!(round == 4'd5 && around_enable) && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        check("reached_round5_ark", int'(round == 4'd5 && around_enable), 1);
        #2 rst = 1'b1;
        #1;
        check("async_reset_outputs", outs(), 0);
        check("async_reset_round", int'(round), 0);
        sbq.delete();
        repeat (3) @(negedge clk);
        check("held_reset_outputs", outs(), 0);
        rst = 1'b0;
        @(negedge clk);
        push_run(0, 144, 0);
        run_block(300);

        // Spurious around_finished during SUB and start during MIX.
        noise_on = 1'b1;
        push_run(0, 144, 0);
        run_block(300);
        noise_on = 1'b0;

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sbq.size(), 0);
        check("idle_at_end", int'(busy), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
